// File: rtl/mcpu_mem_ctrl_if.sv
// Requester-side bundle of the MCPU memory controller: CPU and loader request
// channels plus the shared read-data and busy status.
interface mcpu_mem_ctrl_if #(
  parameter int DRAM_DATA_BITS = 16,
  parameter int DRAM_ADDR_BITS = 14
);
  logic                      cpu_req;
  logic                      cpu_we;
  logic [DRAM_ADDR_BITS-1:0] cpu_addr;
  logic [DRAM_DATA_BITS-1:0] cpu_wdata;
  logic                      cpu_ack;
  logic                      ldr_req;
  logic                      ldr_we;
  logic [DRAM_ADDR_BITS-1:0] ldr_addr;
  logic [DRAM_DATA_BITS-1:0] ldr_wdata;
  logic                      ldr_ack;
  logic [DRAM_DATA_BITS-1:0] rdata;
  logic                      busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  cpu_ack, ldr_ack, rdata, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output cpu_ack, ldr_ack, rdata, busy
  );
endinterface

// File: rtl/mcpu_mem_ctrl.sv
// Round-robin CPU/loader arbiter sequencing single-word DRAM reads and writes
// over a shared tristate data bus; each access ends with a one-cycle ack.
//
//   state    | meaning
//   ST_IDLE  | waiting for a request; arbitrates and latches the winner
//   ST_READ  | dram_re high, DRAM drives data_bus, captured into rdata
//   ST_WRITE | dram_we high, controller drives latched wdata onto data_bus
//   ST_DONE  | ack to the granted requester, requests ignored
module mcpu_mem_ctrl #(
  parameter int DRAM_DATA_BITS = 16,
  parameter int DRAM_ADDR_BITS = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  mcpu_mem_ctrl_if.slave            req_if,
  output logic [DRAM_ADDR_BITS-1:0] dram_addr,
  output logic                      dram_we,
  output logic                      dram_re,
  inout  wire  [DRAM_DATA_BITS-1:0] data_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  state_t                    state, state_nxt;
  logic                      take_grant;
  logic                      pick_ldr;
  logic                      sel_we;
  logic [DRAM_ADDR_BITS-1:0] addr_q;
  logic [DRAM_DATA_BITS-1:0] wdata_q;
  logic [DRAM_DATA_BITS-1:0] rdata_q;
  logic                      gnt_ldr_q;
  logic                      last_ldr_q;
  logic                      cpu_ack;
  logic                      ldr_ack;
  logic                      busy;

  // Loader wins when it is alone, or on a tie when the CPU was served last.
  always_comb begin
    pick_ldr = req_if.ldr_req & (~req_if.cpu_req | ~last_ldr_q);
    sel_we   = pick_ldr ? req_if.ldr_we : req_if.cpu_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    dram_re    = 1'b0;
    dram_we    = 1'b0;
    cpu_ack    = 1'b0;
    ldr_ack    = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req_if.cpu_req || req_if.ldr_req) begin
          take_grant = 1'b1;
          state_nxt  = sel_we ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        dram_re   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_WRITE: begin
        dram_we   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack   = ~gnt_ldr_q;
        ldr_ack   = gnt_ldr_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gnt_ldr_q  <= 1'b0;
      last_ldr_q <= 1'b1;
    end else begin
      if (take_grant) begin
        addr_q     <= pick_ldr ? req_if.ldr_addr  : req_if.cpu_addr;
        wdata_q    <= pick_ldr ? req_if.ldr_wdata : req_if.cpu_wdata;
        gnt_ldr_q  <= pick_ldr;
        last_ldr_q <= pick_ldr;
      end
      if (state == ST_READ) begin
        rdata_q <= data_bus;
      end
    end
  end

  // Bus enable follows the registered-state decode, so reset releases it at once.
  assign data_bus       = dram_we ? wdata_q : {DRAM_DATA_BITS{1'bz}};
  assign dram_addr      = addr_q;
  assign req_if.cpu_ack = cpu_ack;
  assign req_if.ldr_ack = ldr_ack;
  assign req_if.rdata   = rdata_q;
  assign req_if.busy    = busy;

endmodule

// File: tb/tb_mcpu_mem_ctrl.sv
// Self-checking bench for mcpu_mem_ctrl: DRAM model on the tristate bus,
// shadow-memory reference with round-robin prediction, and directed + random scenarios.
module tb_mcpu_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 14;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] dram_addr;
  logic          dram_we;
  logic          dram_re;
  wire  [DW-1:0] data_bus;

  mcpu_mem_ctrl_if #(.DRAM_DATA_BITS(DW), .DRAM_ADDR_BITS(AW)) rif ();

  mcpu_mem_ctrl #(.DRAM_DATA_BITS(DW), .DRAM_ADDR_BITS(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_if    (rif),
    .dram_addr (dram_addr),
    .dram_we   (dram_we),
    .dram_re   (dram_re),
    .data_bus  (data_bus)
  );

  always #5 clk = ~clk;

  // DRAM model plus an extra bench driver used to prove the bus is released.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          probe_en  = 1'b0;
  logic [DW-1:0] probe_val = '0;
  assign data_bus = dram_re  ? mem[dram_addr] : {DW{1'bz}};
  assign data_bus = probe_en ? probe_val      : {DW{1'bz}};
  always @(posedge clk) if (dram_we) mem[dram_addr] <= data_bus;

  int checks = 0;
  int errors = 0;

  // Reference: shadow memory and who was served last.
  bit            m_last_ldr = 1'b1;
  logic [DW-1:0] shadow [int];
  bit            mon_en = 1'b0;

  function automatic logic [DW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset) begin
      checks++;
      if (dram_we && dram_re) begin
        errors++; $display("FAIL mon_excl got we=%0b re=%0b required not both high", dram_we, dram_re);
      end
      if (dram_re) begin
        checks++;
        if ($isunknown(data_bus) || data_bus !== mem[dram_addr]) begin
          errors++; $display("FAIL mon_rbus got=%h required=%h", data_bus, mem[dram_addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rif.cpu_req = 0; rif.cpu_we = 0; rif.cpu_addr = '0; rif.cpu_wdata = '0;
    rif.ldr_req = 0; rif.ldr_we = 0; rif.ldr_addr = '0; rif.ldr_wdata = '0;
  endtask

  task automatic run_single(input bit ldr, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                            output int we_cyc, output int re_cyc, output logic [DW-1:0] wbus,
                            output bit stray);
    lat = -1; rd = '0; we_cyc = 0; re_cyc = 0; wbus = '0; stray = 0;
    if (ldr) begin
      rif.ldr_req = 1; rif.ldr_we = we; rif.ldr_addr = a; rif.ldr_wdata = wd;
    end else begin
      rif.cpu_req = 1; rif.cpu_we = we; rif.cpu_addr = a; rif.cpu_wdata = wd;
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (dram_we) begin we_cyc++; wbus = data_bus; end
      if (dram_re) re_cyc++;
      if (ldr ? rif.cpu_ack : rif.ldr_ack) stray = 1;
      if (ldr ? rif.ldr_ack : rif.cpu_ack) begin lat = c; rd = rif.rdata; break; end
    end
    rif.cpu_req = 0; rif.ldr_req = 0;
    tick();
    if (lat > 0) begin
      m_last_ldr = ldr;
      if (we) shadow[int'(a)] = wd;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (3) tick();
    checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", rif.busy); end
    checks++; if ({dram_we, dram_re} !== 2'b00) begin errors++; $display("FAIL rst_we_re got=%b required=00", {dram_we, dram_re}); end
    checks++; if ({rif.cpu_ack, rif.ldr_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got=%b required=00", {rif.cpu_ack, rif.ldr_ack}); end
    checks++; if (dram_addr !== '0) begin errors++; $display("FAIL rst_addr got=%h required=0", dram_addr); end
    checks++; if (rif.rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h required=0", rif.rdata); end
    reset = 1; m_last_ldr = 1;
    tick();
    checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b required=0", rif.busy); end
  endtask

  task automatic test_cpu_write_read();
    int lat, wc, rc; logic [DW-1:0] rd, wb; bit stray;
    run_single(0, 1, 14'h0005, 16'hBEEF, lat, rd, wc, rc, wb, stray);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_ack_lat got=%0d required=2", lat); end
    checks++; if (wc != 1) begin errors++; $display("FAIL wr_we_cycles got=%0d required=1", wc); end
    checks++; if (wb !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got=%h required=beef", wb); end
    checks++; if (stray) begin errors++; $display("FAIL wr_ldr_ack got=1 required=0"); end
    run_single(0, 0, 14'h0005, 16'h0000, lat, rd, wc, rc, wb, stray);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_ack_lat got=%0d required=2", lat); end
    checks++; if (rd !== shadow_rd(5)) begin errors++; $display("FAIL rd_data got=%h required=%h", rd, shadow_rd(5)); end
    checks++; if (rc != 1 || wc != 0) begin errors++; $display("FAIL rd_cycles got re=%0d we=%0d required re=1 we=0", rc, wc); end
    checks++; if (stray) begin errors++; $display("FAIL rd_ldr_ack got=1 required=0"); end
  endtask

  task automatic test_loader_burst();
    int n = 0, last_c = 0, lat, wc, rc; logic [DW-1:0] rd, wb; bit stray;
    rif.ldr_req = 1; rif.ldr_we = 1; rif.ldr_addr = 14'h3FFC; rif.ldr_wdata = 16'h1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rif.ldr_ack) begin
        checks++;
        if (n == 0 && c != 2) begin errors++; $display("FAIL burst_first got=%0d required=2", c); end
        else if (n > 0 && c - last_c != 3) begin errors++; $display("FAIL burst_space got=%0d required=3", c - last_c); end
        last_c = c;
        shadow[int'(rif.ldr_addr)] = rif.ldr_wdata;
        n++;
        if (n == 4) begin rif.ldr_req = 0; break; end
        rif.ldr_addr = rif.ldr_addr + 1'b1; rif.ldr_wdata = rif.ldr_wdata + 1'b1;
      end
    end
    tick();
    m_last_ldr = 1;
    checks++; if (n != 4) begin errors++; $display("FAIL burst_count got=%0d required=4", n); end
    run_single(0, 0, 14'h3FFF, 16'h0, lat, rd, wc, rc, wb, stray);
    checks++; if (rd !== 16'h1114) begin errors++; $display("FAIL burst_rd3fff got=%h required=1114", rd); end
    run_single(0, 0, 14'h3FFC, 16'h0, lat, rd, wc, rc, wb, stray);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL burst_rd3ffc got=%h required=1111", rd); end
  endtask

  task automatic test_tie();
    bit exp_ldr [4]; int k = 0;
    logic [DW-1:0] cw = DW'($urandom), lw = DW'($urandom);
    reset = 0; clear_inputs();
    tick();
    rif.cpu_req = 1; rif.cpu_we = 1; rif.cpu_addr = 14'h0100; rif.cpu_wdata = cw;
    rif.ldr_req = 1; rif.ldr_we = 1; rif.ldr_addr = 14'h0101; rif.ldr_wdata = lw;
    m_last_ldr = 1;
    for (int i = 0; i < 4; i++) begin exp_ldr[i] = !m_last_ldr; m_last_ldr = exp_ldr[i]; end
    reset = 1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (rif.cpu_ack && rif.ldr_ack) begin checks++; errors++; $display("FAIL tie_both_ack got=11 required=one-hot"); end
      if (rif.cpu_ack || rif.ldr_ack) begin
        checks++;
        if (rif.ldr_ack !== exp_ldr[k]) begin errors++; $display("FAIL tie_order idx=%0d got_ldr=%b required_ldr=%b", k, rif.ldr_ack, exp_ldr[k]); end
        k++;
        if (k == 4) begin rif.cpu_req = 0; rif.ldr_req = 0; break; end
      end
    end
    tick();
    shadow[14'h0100] = cw; shadow[14'h0101] = lw;
    checks++; if (k != 4) begin errors++; $display("FAIL tie_count got=%0d required=4", k); end
  endtask

  task automatic test_bus_monitor();
    int lat, wc, rc; logic [DW-1:0] rd, wb; bit stray;
    logic [AW-1:0] a = AW'($urandom_range(16'h0400, 16'h04FF));
    logic [DW-1:0] d = DW'($urandom);
    mon_en = 1;
    run_single(1, 1, a, d, lat, rd, wc, rc, wb, stray);
    checks++; if (wb !== d) begin errors++; $display("FAIL mon_wbus got=%h required=%h", wb, d); end
    run_single(1, 0, a, '0, lat, rd, wc, rc, wb, stray);
    checks++; if (rd !== shadow_rd(int'(a))) begin errors++; $display("FAIL mon_rdback got=%h required=%h", rd, shadow_rd(int'(a))); end
    probe_val = DW'($urandom); probe_en = 1;
    #1;
    checks++; if (data_bus !== probe_val) begin errors++; $display("FAIL idle_bus_release got=%h required=%h", data_bus, probe_val); end
    probe_en = 0;
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    rif.cpu_req = 1; rif.cpu_we = 1; rif.cpu_addr = 14'h2AAA; rif.cpu_wdata = 16'hA5A5;
    tick();
    checks++; if (dram_we !== 1'b1) begin errors++; $display("FAIL mid_setup_we got=%b required=1", dram_we); end
    #2 reset = 0;
    #1;
    checks++; if ({dram_we, dram_re} !== 2'b00) begin errors++; $display("FAIL mid_we_drop got=%b required=00", {dram_we, dram_re}); end
    checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b required=0", rif.busy); end
    probe_val = 16'h5A5A; probe_en = 1;
    #1;
    checks++; if (data_bus !== 16'h5A5A) begin errors++; $display("FAIL mid_bus_z got=%h required=5a5a", data_bus); end
    probe_en = 0;
    rif.cpu_req = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (rif.cpu_ack || rif.ldr_ack) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_ack got=%0d required=0", seen); end
    rif.cpu_req = 1; rif.cpu_we = 0; rif.cpu_addr = 14'h0005;
    rif.ldr_req = 1; rif.ldr_we = 0; rif.ldr_addr = 14'h3FFC;
    reset = 1; m_last_ldr = 1;
    #1;
    checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL mid_release_busy got=%b required=0", rif.busy); end
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rif.cpu_ack || rif.ldr_ack) begin
        checks++; if (rif.cpu_ack !== 1'b1) begin errors++; $display("FAIL mid_first_tie got_ldr=%b required_ldr=0", rif.ldr_ack); end
        checks++; if (rif.rdata !== shadow_rd(5)) begin errors++; $display("FAIL mid_rdata got=%h required=%h", rif.rdata, shadow_rd(5)); end
        break;
      end
    end
    rif.cpu_req = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rif.ldr_ack) begin
        checks++; if (rif.rdata !== shadow_rd(14'h3FFC)) begin errors++; $display("FAIL mid_ldr_rdata got=%h required=%h", rif.rdata, shadow_rd(14'h3FFC)); end
        break;
      end
    end
    rif.ldr_req = 0;
    tick();
    m_last_ldr = 1;
  endtask

  task automatic test_addr_change();
    rif.cpu_req = 1; rif.cpu_we = 0; rif.cpu_addr = 14'h3FFC;
    tick();
    rif.cpu_addr = 14'h3FFF;
    #1;
    checks++; if (dram_addr !== 14'h3FFC) begin errors++; $display("FAIL achg_dram_addr got=%h required=3ffc", dram_addr); end
    tick();
    checks++; if (rif.cpu_ack !== 1'b1 || rif.rdata !== shadow_rd(14'h3FFC)) begin
      errors++; $display("FAIL achg_rdata got ack=%b data=%h required ack=1 data=%h", rif.cpu_ack, rif.rdata, shadow_rd(14'h3FFC));
    end
    rif.cpu_req = 0;
    tick();
    m_last_ldr = 0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int mask = int'($urandom_range(1, 3));
      bit exp_q [$];
      bit            we [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2];
      for (int r = 0; r < 2; r++) begin
        we[r] = 1'($urandom); ad[r] = AW'(14'h0200 + $urandom_range(0, 7)); wd[r] = DW'($urandom);
      end
      if (mask == 3) begin exp_q.push_back(!m_last_ldr); exp_q.push_back(m_last_ldr); end
      else exp_q.push_back(mask == 2);
      rif.cpu_req = mask[0]; rif.cpu_we = we[0]; rif.cpu_addr = ad[0]; rif.cpu_wdata = wd[0];
      rif.ldr_req = mask[1]; rif.ldr_we = we[1]; rif.ldr_addr = ad[1]; rif.ldr_wdata = wd[1];
      for (int c = 1; c <= 20 && exp_q.size() > 0; c++) begin
        tick();
        if (rif.cpu_ack && rif.ldr_ack) begin checks++; errors++; $display("FAIL rnd_both_ack it=%0d", it); end
        else if (rif.cpu_ack || rif.ldr_ack) begin
          int id = rif.ldr_ack ? 1 : 0;
          checks++;
          if (id != int'(exp_q[0])) begin errors++; $display("FAIL rnd_order it=%0d got_ldr=%0d required_ldr=%0d", it, id, exp_q[0]); end
          id = int'(exp_q.pop_front());
          if (we[id]) shadow[int'(ad[id])] = wd[id];
          else begin
            checks++;
            if (rif.rdata !== shadow_rd(int'(ad[id]))) begin
              errors++; $display("FAIL rnd_rdata it=%0d addr=%h got=%h required=%h", it, ad[id], rif.rdata, shadow_rd(int'(ad[id])));
            end
          end
          if (id == 1) rif.ldr_req = 0; else rif.cpu_req = 0;
          m_last_ldr = (id == 1);
        end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_timeout it=%0d pending=%0d required=0", it, exp_q.size()); end
      clear_inputs();
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    test_reset();
    test_cpu_write_read();
    test_loader_burst();
    test_tie();
    test_bus_monitor();
    test_reset_mid_write();
    test_addr_change();
    test_random();
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mcpu_mem_ctrl.md
Name: mcpu_mem_ctrl

Overview:
Memory controller directly upstream of the MCPU DRAM. It arbitrates between two requesters, the CPU and the program loader/DMA port, using round-robin. It sequences one single-word read or write at a time onto the DRAM's address, read-enable and write-enable lines and the shared tristate data bus. Each access completes with a one-cycle ack to the granted requester.

Parameters:
DRAM_DATA_BITS, 16, data word width (matches DRAM)
DRAM_ADDR_BITS, 14, word address width (matches DRAM)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU requests a transaction (level)
cpu_we  input  1  1=write, 0=read; sampled at grant
cpu_addr  input  DRAM_ADDR_BITS  CPU word address; sampled at grant
cpu_wdata  input  DRAM_DATA_BITS  CPU write data; sampled at grant
cpu_ack  output  1  one-cycle completion pulse to CPU
ldr_req  input  1  loader requests a transaction (level)
ldr_we  input  1  1=write, 0=read; sampled at grant
ldr_addr  input  DRAM_ADDR_BITS  loader word address
ldr_wdata  input  DRAM_DATA_BITS  loader write data
ldr_ack  output  1  one-cycle completion pulse to loader
rdata  output  DRAM_DATA_BITS  registered read data, valid in the ack cycle and held until the next read completes
busy  output  1  high whenever state != IDLE
dram_addr  output  DRAM_ADDR_BITS  DRAM word address
dram_we  output  1  DRAM write enable
dram_re  output  1  DRAM read enable (DRAM drives data_bus while high)
data_bus  inout  DRAM_DATA_BITS  shared bus; driven by controller only in WRITE state, else Z

Behaviour:
- States: IDLE, READ, WRITE, DONE. All registers are reset asynchronously when reset=0.
- Reset values:
  - state=IDLE; all outputs 0.
  - data_bus=Z; dram_addr=0; rdata=0.
  - last_grant=LDR, so the CPU wins the first tie.
- IDLE behaviour:
  - At a rising edge with any req high, the controller selects a winner.
  - Only one requester high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - On grant, latch the winner's we, addr and wdata, and the grant id; update last_grant.
  - Next state is WRITE if we=1, else READ.
  - No req: stay in IDLE.
- READ (one cycle):
  - dram_re=1, dram_addr=latched addr, data_bus released.
  - At the closing edge, capture data_bus into rdata. Next state DONE.
- WRITE (one cycle):
  - dram_we=1, dram_addr=latched addr, data_bus driven with latched wdata.
  - The DRAM commits at the closing edge. Next state DONE.
- DONE (one cycle):
  - The granted requester's ack=1; the other ack stays 0.
  - dram_re, dram_we and data_bus drive are inactive.
  - Requests are ignored in this state. Next state IDLE.
- dram_we and dram_re are combinational decodes of registered state only; they are never both 1.
  - The controller drives data_bus only when dram_we=1, so bus contention is impossible by construction.
- Latency: request sampled at edge E0 → access cycle after E0 → ack high in the cycle after E1 → IDLE after E2.
  - Minimum 3 cycles per transaction.
  - A requester that holds req high through ack starts its next transaction at E2+1 at the earliest, subject to arbitration.
- Requester rules:
  - Hold req, we, addr and wdata stable until granted. Fields are captured at the grant edge, so changes afterwards have no effect.
  - Dropping req before the grant withdraws the request; dropping it after the grant does not cancel the transaction.
- Reset mid-transaction:
  - dram_we and dram_re drop immediately (asynchronously) and the bus goes to Z.
  - No ack is issued. A write in flight may or may not have committed.
- Addresses pass through unmodified, with no wrap or range checking; width equals DRAM_ADDR_BITS.

Test Plan:
- CPU write addr 0x0005 data 0xBEEF, then CPU read addr 0x0005:
  - write: dram_we=1 for exactly one cycle with data_bus=0xBEEF; cpu_ack one cycle later.
  - read: rdata=0xBEEF in the cpu_ack cycle; ldr_ack stays 0 throughout.
- Loader writes 0x1111..0x1114 to addrs 0x3FFC..0x3FFF with ldr_req held high:
  - exactly 4 ldr_acks, spaced 3 cycles apart.
  - CPU reads of 0x3FFF return 0x1114.
- cpu_req and ldr_req both held high from reset release, 4 transactions:
  - grant order CPU, LDR, CPU, LDR; acks alternate.
- Write then immediate read by the same requester, with a bus monitor every cycle:
  - data_bus is never X while dram_re=1.
  - dram_we and dram_re are never both high.
  - the controller drives data_bus only in WRITE cycles.
- Assert reset=0 asynchronously during a WRITE cycle:
  - dram_we drops before the next clock edge; data_bus goes to Z; no ack.
  - after release, state is IDLE, busy=0, and the CPU wins the first tie.
- cpu_addr changed during READ after grant:
  - dram_addr keeps the latched address; rdata reflects the original address.
